fifo_ptr_flag_gen: RTL
======================

Name: fifo_ptr_flag_gen

Overview:
Pointer-crossing and flag stage for one side of the async FIFO. It sits directly downstream of the read or write pointer controller.
- Consumes that controller's binary pointer.
- Exports a registered Gray copy of the pointer to the opposite clock domain.
- Synchronises the opposite domain's Gray pointer into clk.
- Produces the fe_flag (full on the write side, empty on the read side), plus an almost flag and a fill level.
One instance is used per side.

Parameters:
- DEEPWID, 3: address width; FIFO depth = 2**DEEPWID; pointers are DEEPWID+1 bits wide.
- IS_WR, 1: 1 = write side (fe_flag means full); 0 = read side (fe_flag means empty).
- SYNC_STAGES, 2: flop count in the remote-pointer synchroniser; must be >= 2.
- ALMOST_TH, 6: threshold for almost_flag, in entries.

Ports:
- clk  input  1  local-domain clock
- rst_n  input  1  asynchronous active-low reset
- addr_local  input  DEEPWID+1  binary pointer from the local pointer controller (a registered signal)
- ptr_remote_gray  input  DEEPWID+1  Gray pointer from the opposite domain; asynchronous to clk
- ptr_local_gray  output  DEEPWID+1  registered Gray encoding of addr_local, sent to the opposite domain
- fe_flag  output  1  full (IS_WR=1) or empty (IS_WR=0); feeds the controller's fe_flag input
- almost_flag  output  1  almost-full (IS_WR=1) or almost-empty (IS_WR=0)
- level  output  DEEPWID+1  current fill level as seen from this domain, range 0..2**DEEPWID

Behaviour:
- Reset (rst_n low, asynchronous):
  - All synchroniser flops and ptr_local_gray clear to 0.
  - Write side: fe_flag=0, level=0, almost_flag=(0>=ALMOST_TH).
  - Read side: fe_flag=1, level=0, almost_flag=1.
- Local Gray export:
  - ptr_local_gray <= addr_local ^ (addr_local >> 1) on every clk edge.
  - One-cycle latency. The value comes from a flop only, with no combinational path to the output.
- Remote synchroniser:
  - ptr_remote_gray passes through a SYNC_STAGES-deep flop chain.
  - The last stage is converted Gray->binary combinationally to give remote_bin.
  - A change on ptr_remote_gray is visible in remote_bin SYNC_STAGES edges later.
- Level, mod 2**(DEEPWID+1) arithmetic, DEEPWID+1 result width, wrap-around handled by truncation:
  - Write side: level = addr_local - remote_bin.
  - Read side: level = remote_bin - addr_local.
- Flags are combinational from registered signals only (addr_local and the last sync stage), so there are no glitch sources from the other domain:
  - Write side: fe_flag = (level == 2**DEEPWID), which is equivalent to the MSBs differing and the lower bits being equal.
  - Read side: fe_flag = (level == 0).
  - Write side: almost_flag = (level >= ALMOST_TH).
  - Read side: almost_flag = (level <= ALMOST_TH).
- Timing of flag updates:
  - A local pointer increment updates fe_flag in the same cycle addr_local changes. No extra latency, so the controller cannot over- or under-run.
  - A remote pointer move is seen late by SYNC_STAGES+1 cycles: 1 export register plus SYNC_STAGES. This is pessimistic by construction: full or empty may stay asserted longer, but is never deasserted early.
- Simultaneous local and remote movement: each side is evaluated independently each cycle, with no priority logic.
- Level never exceeds 2**DEEPWID provided the controller honours fe_flag. An out-of-range level is a controller bug and is flagged by an assertion.
- Reset mid-operation: outputs return to their reset values immediately. No flush sequencing is required, because both domains are reset together.

Decomposition:
- Shared package/include file:
  - functions bin2gray and gray2bin, parameterised on width;
  - PTR_W = DEEPWID+1 constant.
- One sub-module: gray_sync_chain (SYNC_STAGES-deep, width-parameterised, async reset to 0). It is reused by any other CDC bus in the FIFO.

Test Plan:
- Reset:
  - IS_WR=1, DEEPWID=3: hold rst_n=0 -> fe_flag=0, level=0, ptr_local_gray=0.
  - IS_WR=0: -> fe_flag=1, almost_flag=1.
- Fill to full: IS_WR=1, ptr_remote_gray=0; step addr_local 0->8, one per cycle.
  - level follows 0..8.
  - almost_flag rises at addr_local=6.
  - fe_flag=1 exactly when addr_local=4'b1000.
- Sync latency: IS_WR=0, addr_local=0; drive ptr_remote_gray=4'b0001 at edge N.
  - fe_flag stays 1 through edge N+1.
  - fe_flag falls and level=1 after edge N+2 (SYNC_STAGES=2).
- Wrap full: IS_WR=1, addr_local=4'b0011, remote binary 11 (Gray 4'b1110) settled -> level=8, fe_flag=1.
  - Then remote binary 12 (Gray 4'b1010) -> fe_flag=0 after 2 edges, level=7.
- Gray export:
  - addr_local=5 -> ptr_local_gray=4'b0111 one edge later.
  - addr_local 15 -> 0 -> ptr_local_gray 4'b1000 -> 4'b0000.
  - Check that only one bit changes per increment across a full 0..15 sweep.
- Reset mid-operation: write side held full (level=8); pulse rst_n low between clock edges.
  - fe_flag drops to 0 and ptr_local_gray goes to 0 asynchronously, without waiting for a clk edge.
  - Normal operation resumes after release.

Source files
------------

// File: rtl/fifo_ptr_flag_gen_pkg.sv
// Shared definitions for the async FIFO pointer-crossing logic:
// Gray/binary conversion helpers and the default pointer width.
package fifo_ptr_flag_gen_pkg;

    localparam int DEEPWID_DFLT = 3;
    localparam int PTR_W        = DEEPWID_DFLT + 1;

    // Conversions work on a zero-extended 32-bit carrier. For Gray codes this
    // is width-independent: zero upper bits contribute nothing to the
    // prefix-XOR, so callers widen on the way in and truncate on the way out.
    localparam int GRAY_MAX_W = 32;
    typedef logic [GRAY_MAX_W-1:0] gray_vec_t;

    // Which side of the FIFO an instance serves.
    typedef enum logic {
        SIDE_RD = 1'b0,
        SIDE_WR = 1'b1
    } fifo_side_e;

    function automatic gray_vec_t bin2gray(input gray_vec_t b);
        return b ^ (b >> 1);
    endfunction

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic gray_vec_t gray2bin(input gray_vec_t g);
        gray_vec_t b;
        b = g;
        for (int i = 1; i < GRAY_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_flag_gen_gray_sync_chain.sv
// Multi-flop synchroniser for a Gray-coded bus arriving from another clock
// domain. Only one bit changes per source update, so each stage can sample
// the bus independently without producing a torn value.
module gray_sync_chain #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_d [STAGES];
    logic [WIDTH-1:0] sync_q [STAGES];

    // Stage 0 samples the asynchronous input; each later stage samples its predecessor.
    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops, cleared asynchronously so both domains start aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_ptr_flag_gen.sv
// Pointer-crossing and flag stage for one side of the async FIFO.
// Exports the local pointer in Gray code, synchronises the remote Gray
// pointer, and derives full/empty, almost and fill level in this domain.
module fifo_ptr_flag_gen
    import fifo_ptr_flag_gen_pkg::*;
#(
    parameter int DEEPWID     = 3,
    parameter int IS_WR       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int ALMOST_TH   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DEEPWID:0]   addr_local,
    input  logic [DEEPWID:0]   ptr_remote_gray,
    output logic [DEEPWID:0]   ptr_local_gray,
    output logic               fe_flag,
    output logic               almost_flag,
    output logic [DEEPWID:0]   level
);

    localparam int              PW    = DEEPWID + 1;
    localparam logic [PW-1:0]   DEPTH = {1'b1, {DEEPWID{1'b0}}};
    localparam logic [31:0]     TH    = 32'(ALMOST_TH);
    localparam fifo_side_e      SIDE  = (IS_WR != 0) ? SIDE_WR : SIDE_RD;

    logic [PW-1:0] ptr_local_gray_d;
    logic [PW-1:0] ptr_local_gray_q;
    logic [PW-1:0] remote_gray_sync;
    logic [PW-1:0] remote_bin;
    logic [PW-1:0] level_raw;
    logic [PW-1:0] level_w;
    logic          fe_w;
    logic          almost_w;

    // Gray encoding of the local pointer; registered before crossing domains.
    always_comb begin
        ptr_local_gray_d = PW'(bin2gray(32'(addr_local)));
    end

    // Export register: the opposite domain only ever sees a flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_local_gray_q <= '0;
        end else begin
            ptr_local_gray_q <= ptr_local_gray_d;
        end
    end

    assign ptr_local_gray = ptr_local_gray_q;

    gray_sync_chain #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ptr_remote_gray),
        .q     (remote_gray_sync)
    );

    // Level and flags from registered sources only (addr_local and the last
    // sync stage). Wrap-around is absorbed by PW-bit truncating subtraction.
    // While reset is held the level is forced to zero so the flags take their
    // reset values at once, even if the controller's pointer has not cleared yet.
    always_comb begin
        remote_bin = PW'(gray2bin(32'(remote_gray_sync)));
        level_raw  = '0;
        fe_w       = 1'b0;
        almost_w   = 1'b0;
        case (SIDE)
            SIDE_WR: level_raw = addr_local - remote_bin;
            default: level_raw = remote_bin - addr_local;
        endcase
        level_w = rst_n ? level_raw : '0;
        case (SIDE)
            SIDE_WR: begin
                fe_w     = (level_w == DEPTH);
                almost_w = (32'(level_w) >= TH);
            end
            default: begin
                fe_w     = (level_w == '0);
                almost_w = (32'(level_w) <= TH);
            end
        endcase
    end

    assign level       = level_w;
    assign fe_flag     = fe_w;
    assign almost_flag = almost_w;

    // A level above the FIFO depth means the pointer controller ignored fe_flag.
    level_in_range: assert property (@(posedge clk) disable iff (!rst_n) (level_raw <= DEPTH));

endmodule
